// File: rtl/shared_adder_arbiter.sv
// rtl/shared_adder_arbiter.sv - round-robin arbiter sharing one adder among NUM_REQ requesters
//
// Ports:
//   clock__i      single clock, rising edge
//   reset_n__i    asynchronous active-low reset
//   reqValid__i   per-requester operation present
//   reqDataA__i   packed operand A, requester k at [k*WIDTH +: WIDTH]
//   reqDataB__i   packed operand B, same packing
//   reqReady__o   one-hot grant, accepted on valid & ready at a clock edge
//   rspValid__o   result register holds a valid result
//   rspReady__i   consumer accepts the result
//   rspData__o    sum modulo 2^WIDTH
//   rspCarry__o   carry out of the addition
//   rspId__o      requester that owns the result
module shared_adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                       clock__i,
  input  logic                       reset_n__i,
  input  logic [NUM_REQ-1:0]         reqValid__i,
  input  logic [NUM_REQ*WIDTH-1:0]   reqDataA__i,
  input  logic [NUM_REQ*WIDTH-1:0]   reqDataB__i,
  output logic [NUM_REQ-1:0]         reqReady__o,
  output logic                       rspValid__o,
  input  logic                       rspReady__i,
  output logic [WIDTH-1:0]           rspData__o,
  output logic                       rspCarry__o,
  output logic [$clog2(NUM_REQ)-1:0] rspId__o
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             slot_free;
  logic             accept;
  logic [ID_W:0]    scan_sum;
  logic [ID_W-1:0]  scan_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;
  logic [ID_W-1:0]  ptr_next;

  assign slot_free = !rspValid__o || rspReady__i;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
  // Only reqValid__i and ptr feed this, so the grant never sees operand data.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_any && reqValid__i[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  // Reset gates the grant directly: the register is already clear, so slot_free
  // alone would let a grant through while reset is held.
  assign accept = grant_any && slot_free && reset_n__i;

  always_comb begin
    reqReady__o = '0;
    a_sel       = '0;
    b_sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        reqReady__o[k] = accept;
        a_sel          = reqDataA__i[k*WIDTH +: WIDTH];
        b_sel          = reqDataB__i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // A drain and a new acceptance in the same cycle simply overwrite the
  // register, giving one operation per cycle.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      rspValid__o <= 1'b0;
      rspData__o  <= '0;
      rspCarry__o <= 1'b0;
      rspId__o    <= '0;
      ptr         <= '0;
    end else if (accept) begin
      rspValid__o <= 1'b1;
      rspData__o  <= sum_full[WIDTH-1:0];
      rspCarry__o <= sum_full[WIDTH];
      rspId__o    <= grant_id;
      ptr         <= ptr_next;
    end else if (rspReady__i) begin
      rspValid__o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb/tb_shared_adder_arbiter.sv - directed self-checking bench for shared_adder_arbiter
module tb_shared_adder_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;
  logic [1:0]               rsp_id;

  int n_cmp = 0;
  int n_err = 0;

  shared_adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clock__i    (clk),
    .reset_n__i  (rst_n),
    .reqValid__i (req_valid),
    .reqDataA__i (req_a),
    .reqDataB__i (req_b),
    .reqReady__o (req_ready),
    .rspValid__o (rsp_valid),
    .rspReady__i (rsp_ready),
    .rspData__o  (rsp_data),
    .rspCarry__o (rsp_carry),
    .rspId__o    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rsp_data); end
    n_cmp++; if (rsp_carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", rsp_carry); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  // Single request to requester 2, then ptr=3 is seen as a grant to 3 out of 1111.
  task automatic test_single;
    set_op(2, 32'd5, 32'd7);
    set_op(3, 32'd10, 32'd20);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd12) begin n_err++; $display("FAIL single_data got %0d want 12", rsp_data); end
    n_cmp++; if (rsp_carry !== 1'b0) begin n_err++; $display("FAIL single_carry got %b want 0", rsp_carry); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id got %0d want 2", rsp_id); end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL single_ptr3 got %b want 1000", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_id !== 2'd3 || rsp_data !== 32'd30) begin n_err++; $display("FAIL single_next got id %0d data %0d want id 3 data 30", rsp_id, rsp_data); end
  endtask

  // ptr is 0 here after the wrap from requester 3.
  task automatic test_carry;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL carry_ready got %b want 0001", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_data !== 32'h0000_0001) begin n_err++; $display("FAIL carry_data got %h want 00000001", rsp_data); end
    n_cmp++; if (rsp_carry !== 1'b1) begin n_err++; $display("FAIL carry_carry got %b want 1", rsp_carry); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL carry_id got %0d want 0", rsp_id); end
  endtask

  // ptr is 1; one grant to 3 brings it back to 0, then 1111 rotates 0,1,2,3,0.
  task automatic test_round_robin;
    logic [3:0] exp_r;
    int         g;
    for (int k = 0; k < NUM_REQ; k++) set_op(k, 32'(100 + k), 32'(k));
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_setup got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g     = i % NUM_REQ;
      exp_r = 4'b0001 << g;
      #1;
      n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, exp_r); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== 32'(100 + 2 * g))
        begin n_err++; $display("FAIL rr_rsp[%0d] got v%b id %0d data %0d want v1 id %0d data %0d", i, rsp_valid, rsp_id, rsp_data, g, 100 + 2 * g); end
    end
  endtask

  // Result {id 0, 100} pending, ptr=1.
  task automatic test_backpressure;
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd100)
        begin n_err++; $display("FAIL bp_hold[%0d] got v%b id %0d data %0d want v1 id 0 data 100", i, rsp_valid, rsp_id, rsp_data); end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release got %b want 0010", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'd102)
      begin n_err++; $display("FAIL bp_overwrite got v%b id %0d data %0d want v1 id 1 data 102", rsp_valid, rsp_id, rsp_data); end
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", rsp_valid); end
  endtask

  // ptr=2 on entry.
  task automatic test_wrap_skip;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_ready got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1101;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL skip_ptr2 got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ready got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ptr0 got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  // ptr=1 on entry; grant 2 and hold the result, then reset between edges.
  task automatic test_reset_midflight;
    for (int k = 0; k < NUM_REQ; k++) set_op(k, 32'(k * 3), 32'd1);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL mid_pending got v%b id %0d want v1 id 2", rsp_valid, rsp_id); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_async_clear got data %0d id %0d want 0 0", rsp_data, rsp_id); end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_regrant got %b want 0010", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'd4)
      begin n_err++; $display("FAIL mid_rsp got v%b id %0d data %0d want v1 id 1 data 4", rsp_valid, rsp_id, rsp_data); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
